slot_busy_tracker: RTL and testbench
====================================

// Module: slot_busy_tracker
// PURPOSE
//  Decode-side partner of the lowest-index grant encoder. Takes slot indices
//  (e.g. allocated issue-queue/RS entries) and decodes them to one-hot.
//  Keeps a registered busy vector of WIDTH slots, updated by a set port
//  (allocate) and a clear port (release).
//  Drives busy/full/empty/free-count back to the requester side, plus
//  one-cycle error pulses for illegal or redundant indices.
// PARAMETERS
//  WIDTH   6                  number of tracked slots (>=2, need not be pow2)
//  IDX_W   $clog2(WIDTH)      index width; codes >= WIDTH are illegal
//  CNT_W   $clog2(WIDTH+1)    free-count width
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      synchronous reset, active-low (sampled on clk)
//  set_valid  in   1      request to mark slot set_idx busy
//  set_ready  out  1      set accepted this cycle; = ~full (from registered state)
//  set_idx    in   IDX_W  slot to allocate
//  clr_valid  in   1      release slot clr_idx (always accepted, no ready)
//  clr_idx    in   IDX_W  slot to release
//  busy       out  WIDTH  registered busy vector, bit i = slot i allocated
//  free_cnt   out  CNT_W  registered count of zero bits in busy
//  full       out  1      registered, free_cnt == 0
//  empty      out  1      registered, free_cnt == WIDTH
//  err_range  out  1      registered pulse: a valid index >= WIDTH seen last cycle
//  err_dbl    out  1      registered pulse: set of busy slot / clear of free slot
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): busy=0, free_cnt=WIDTH, full=0, empty=1, errs=0.
//    Reset mid-operation discards all state; inputs during reset are ignored.
//  - Decode: set_oh = (set_valid & set_ready & idx<WIDTH) ? 1<<set_idx : 0.
//    clr_oh = (clr_valid & idx<WIDTH) ? 1<<clr_idx : 0.
//  - Update: busy_n = (busy & ~clr_oh) | set_oh. All outputs are one-cycle
//    latency; set_ready is combinational from registered full only.
//  - Simultaneous set+clr, same idx, slot busy: slot stays busy (release then
//    reuse), no error, free_cnt unchanged.
//  - Simultaneous set+clr, different idx: both apply; free_cnt unchanged.
//  - Set to busy slot not cleared this cycle: no state change, err_dbl=1 next cycle.
//  - Clear of free slot: no state change, err_dbl=1 next cycle.
//  - Illegal index (>=WIDTH) on either accepted port: decodes to 0, err_range=1
//    next cycle; the other port still applies.
//  - Set while full: set_ready=0, request ignored, no error. A same-cycle clear
//    does not raise set_ready (no combinational bypass).
//  - free_cnt_n = popcount(~busy_n); full/empty derive from free_cnt_n and are
//    registered with it. free_cnt never leaves [0,WIDTH].
//  - Error outputs are single-cycle pulses, not sticky; both may assert together.
// STRUCTURE
//  - Shared package slot_pkg: localparams for IDX_W and CNT_W derivation,
//    typedef slot_idx_t, and function popcount_free().
//  - Sub-module idx_onehot_decoder (combinational: idx, en -> onehot, in_range),
//    instantiated twice (set, clr). Top holds busy/free_cnt/flag registers.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with set_valid=1 idx=2
//    -> busy=0, free_cnt=6, empty=1, full=0.
//  2 Fill: set idx 0..5 on consecutive cycles -> busy=6'h3F, free_cnt=0,
//    full=1, set_ready=0; extra set idx=1 ignored, err_dbl=0.
//  3 Same-idx reuse: busy=6'h3F, set=3 and clr=3 same cycle with full
//    -> set not accepted, busy=6'h37; from busy=6'h08 -> busy stays 6'h08, no err.
//  4 Errors: clr idx=4 with busy=0 -> err_dbl pulse 1 cycle, busy=0;
//    set idx=7 -> err_range pulse, busy unchanged.
//  5 Mixed: busy=6'h05, set=1 and clr=2 -> busy=6'h03, free_cnt=4.
//  6 Mid-op reset: busy=6'h2A, rst_n=0 one cycle -> busy=0, free_cnt=6 next cycle.

Source files
------------

// File: rtl/slot_pkg.sv
// Shared definitions for the slot busy tracker: default slot count, derived
// index/count widths, the slot index type and the free-slot popcount.
package slot_pkg;

    localparam int SLOT_WIDTH = 6;
    localparam int SLOT_IDX_W = $clog2(SLOT_WIDTH);
    localparam int SLOT_CNT_W = $clog2(SLOT_WIDTH + 1);
    localparam int MAX_WIDTH  = 64;

    typedef logic [SLOT_IDX_W-1:0] slot_idx_t;

    // Counts zero bits among the low n bits of vec (upper bits are ignored).
    function automatic int popcount_free(input logic [MAX_WIDTH-1:0] vec, input int n);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < n && !vec[i]) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/idx_onehot_decoder.sv
// Combinational slot index to one-hot decoder with range check; codes at or
// above WIDTH decode to all-zero and clear in_range.
module idx_onehot_decoder #(
    parameter int WIDTH = 6,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [WIDTH-1:0] onehot,
    output logic             in_range
);

    // Compare with one extra bit so a power-of-two WIDTH does not wrap to 0.
    assign in_range = ({1'b0, idx} < (IDX_W + 1)'(WIDTH));
    assign onehot   = (en && in_range) ? (WIDTH'(1) << idx) : '0;

endmodule

// File: rtl/slot_busy_tracker.sv
// Registered busy vector for WIDTH allocatable slots with allocate/release
// ports, free count, full/empty flags and one-cycle error pulses.
module slot_busy_tracker
    import slot_pkg::*;
#(
    parameter int WIDTH = SLOT_WIDTH,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_valid,
    output logic             set_ready,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_valid,
    input  logic [IDX_W-1:0] clr_idx,
    output logic [WIDTH-1:0] busy,
    output logic [CNT_W-1:0] free_cnt,
    output logic             full,
    output logic             empty,
    output logic             err_range,
    output logic             err_dbl
);

    logic             set_acc;
    logic [WIDTH-1:0] set_oh;
    logic [WIDTH-1:0] clr_oh;
    logic             set_in_range;
    logic             clr_in_range;
    logic [WIDTH-1:0] busy_n;
    logic [CNT_W-1:0] free_cnt_n;
    logic             err_range_n;
    logic             err_dbl_n;

    // Ready comes from registered state only; a same-cycle release cannot open it.
    assign set_ready = ~full;
    assign set_acc   = set_valid & set_ready;

    idx_onehot_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_set_dec (
        .idx      (set_idx),
        .en       (set_acc),
        .onehot   (set_oh),
        .in_range (set_in_range)
    );

    idx_onehot_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_clr_dec (
        .idx      (clr_idx),
        .en       (clr_valid),
        .onehot   (clr_oh),
        .in_range (clr_in_range)
    );

    // Release applies before allocate, so set+clr of one busy slot keeps it busy.
    assign busy_n     = (busy & ~clr_oh) | set_oh;
    assign free_cnt_n = CNT_W'(popcount_free(MAX_WIDTH'(busy_n), WIDTH));

    assign err_range_n = (set_acc & ~set_in_range) | (clr_valid & ~clr_in_range);
    assign err_dbl_n   = (|(set_oh & busy & ~clr_oh)) | (|(clr_oh & ~busy));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= '0;
            free_cnt  <= CNT_W'(WIDTH);
            full      <= 1'b0;
            empty     <= 1'b1;
            err_range <= 1'b0;
            err_dbl   <= 1'b0;
        end else begin
            busy      <= busy_n;
            free_cnt  <= free_cnt_n;
            full      <= (free_cnt_n == '0);
            empty     <= (free_cnt_n == CNT_W'(WIDTH));
            err_range <= err_range_n;
            err_dbl   <= err_dbl_n;
        end
    end

endmodule

// File: tb/tb_slot_busy_tracker.sv
// Scoreboard bench for slot_busy_tracker: a per-slot reference model pushes
// expected next-cycle outputs, which are popped and compared after each edge.
module tb_slot_busy_tracker;
    import slot_pkg::*;

    localparam int W = 6;

    typedef struct packed {
        logic [W-1:0] busy;
        logic [2:0]   free_cnt;
        logic         full;
        logic         empty;
        logic         err_range;
        logic         err_dbl;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         set_valid;
    logic         set_ready;
    slot_idx_t    set_idx;
    logic         clr_valid;
    slot_idx_t    clr_idx;
    logic [W-1:0] busy;
    logic [2:0]   free_cnt;
    logic         full;
    logic         empty;
    logic         err_range;
    logic         err_dbl;

    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    logic [W-1:0] m_busy;
    logic         m_full;

    slot_busy_tracker #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (set_valid),
        .set_ready (set_ready),
        .set_idx   (set_idx),
        .clr_valid (clr_valid),
        .clr_idx   (clr_idx),
        .busy      (busy),
        .free_cnt  (free_cnt),
        .full      (full),
        .empty     (empty),
        .err_range (err_range),
        .err_dbl   (err_dbl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Reference model: slot-by-slot rules, then push the expected registered outputs.
    function automatic exp_t model_step(input logic rst, input logic sv, input int si,
                                        input logic cv, input int ci);
        exp_t e;
        logic ready;
        int   cnt;
        ready = !m_full;
        e = '0;
        if (sv && ready && si >= W) e.err_range = 1'b1;
        if (cv && ci >= W) e.err_range = 1'b1;
        for (int i = 0; i < W; i++) begin
            logic s, c;
            s = sv && ready && (si == i);
            c = cv && (ci == i);
            if (c && !m_busy[i]) e.err_dbl = 1'b1;
            if (s && m_busy[i] && !c) e.err_dbl = 1'b1;
            if (s) e.busy[i] = 1'b1;
            else if (c) e.busy[i] = 1'b0;
            else e.busy[i] = m_busy[i];
        end
        if (!rst) begin
            e = '0;
        end
        cnt = 0;
        for (int i = 0; i < W; i++) if (!e.busy[i]) cnt++;
        e.free_cnt = 3'(cnt);
        e.full     = (cnt == 0);
        e.empty    = (cnt == W);
        return e;
    endfunction

    task automatic cycle(input logic rst, input logic sv, input int si,
                         input logic cv, input int ci);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst_n     = rst;
        set_valid = sv;
        set_idx   = slot_idx_t'(si);
        clr_valid = cv;
        clr_idx   = slot_idx_t'(ci);
        e = model_step(rst, sv, si, cv, ci);
        exp_q.push_back(e);
        m_busy = e.busy;
        m_full = e.full;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            check("busy",      32'(busy),      32'(got.busy));
            check("free_cnt",  32'(free_cnt),  32'(got.free_cnt));
            check("full",      32'(full),      32'(got.full));
            check("empty",     32'(empty),     32'(got.empty));
            check("err_range", 32'(err_range), 32'(got.err_range));
            check("err_dbl",   32'(err_dbl),   32'(got.err_dbl));
            check("set_ready", 32'(set_ready), 32'(!got.full));
        end
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 0, 1'b0, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        m_busy    = '0;
        m_full    = 1'b0;
        rst_n     = 1'b0;
        set_valid = 1'b0;
        set_idx   = '0;
        clr_valid = 1'b0;
        clr_idx   = '0;

        // Reset held three cycles while a set request is presented
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 2, 1'b0, 0);
        check("rst_busy",  32'(busy),     32'h0);
        check("rst_free",  32'(free_cnt), 32'd6);
        check("rst_empty", 32'(empty),    32'd1);
        check("rst_full",  32'(full),     32'd0);

        // Fill all slots, then an extra set is ignored without error
        for (int k = 0; k < W; k++) cycle(1'b1, 1'b1, k, 1'b0, 0);
        check("fill_busy",  32'(busy),      32'h3F);
        check("fill_free",  32'(free_cnt),  32'd0);
        check("fill_full",  32'(full),      32'd1);
        check("fill_ready", 32'(set_ready), 32'd0);
        cycle(1'b1, 1'b1, 1, 1'b0, 0);
        check("full_set_busy", 32'(busy),    32'h3F);
        check("full_set_dbl",  32'(err_dbl), 32'd0);

        // Set+clr same index while full: only the clear lands
        cycle(1'b1, 1'b1, 3, 1'b1, 3);
        check("full_reuse_busy", 32'(busy), 32'h37);

        // Same-index reuse on a busy slot with room available
        cycle(1'b0, 1'b0, 0, 1'b0, 0);
        cycle(1'b1, 1'b1, 3, 1'b0, 0);
        check("reuse_pre", 32'(busy), 32'h08);
        cycle(1'b1, 1'b1, 3, 1'b1, 3);
        check("reuse_busy",  32'(busy),      32'h08);
        check("reuse_dbl",   32'(err_dbl),   32'd0);
        check("reuse_range", 32'(err_range), 32'd0);
        check("reuse_free",  32'(free_cnt),  32'd5);

        // Error pulses: clear of free slot, then out-of-range set
        cycle(1'b1, 1'b0, 0, 1'b1, 3);
        cycle(1'b1, 1'b0, 0, 1'b1, 4);
        check("clr_free_dbl",  32'(err_dbl), 32'd1);
        check("clr_free_busy", 32'(busy),    32'h0);
        idle();
        check("dbl_pulse_end", 32'(err_dbl), 32'd0);
        cycle(1'b1, 1'b1, 7, 1'b0, 0);
        check("range_pulse", 32'(err_range), 32'd1);
        check("range_busy",  32'(busy),      32'h0);
        idle();
        check("range_pulse_end", 32'(err_range), 32'd0);

        // Mixed set and clear on different slots
        cycle(1'b1, 1'b1, 0, 1'b0, 0);
        cycle(1'b1, 1'b1, 2, 1'b0, 0);
        cycle(1'b1, 1'b1, 1, 1'b1, 2);
        check("mixed_busy", 32'(busy),     32'h03);
        check("mixed_free", 32'(free_cnt), 32'd4);

        // Mid-operation reset
        cycle(1'b0, 1'b0, 0, 1'b0, 0);
        cycle(1'b1, 1'b1, 1, 1'b0, 0);
        cycle(1'b1, 1'b1, 3, 1'b0, 0);
        cycle(1'b1, 1'b1, 5, 1'b0, 0);
        check("midrst_pre", 32'(busy), 32'h2A);
        cycle(1'b0, 1'b1, 0, 1'b1, 1);
        check("midrst_busy", 32'(busy),     32'h0);
        check("midrst_free", 32'(free_cnt), 32'd6);

        // Random traffic including illegal codes and occasional reset
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 49) != 0),
                  1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 2) == 0), int'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
